// File: rtl/operand_fwd_unit_pkg.sv
// Shared types for the ID/EX operand-delivery stage: bypass source ids,
// source-mux selects and the ID_EX control slot.
package operand_fwd_unit_pkg;

  // Register addresses are carried at this width inside slots; narrower
  // AW values are zero-extended so compares stay full-width.
  localparam int SLOT_AW = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_S1   = 2'd1,
    FWD_S2   = 2'd2,
    FWD_S3   = 2'd3
  } fwd_sel_t;

  typedef enum logic [2:0] {
    SRC0_RF    = 3'd0,
    SRC0_IMM7  = 3'd1,
    SRC0_IMM12 = 3'd2,
    SRC0_IMM15 = 3'd3,
    SRC0_SP    = 3'd4,
    SRC0_MULH  = 3'd5,
    SRC0_ZERO  = 3'd6
  } src0sel_t;

  typedef enum logic [1:0] {
    SRC1_RF   = 2'd0,
    SRC1_IMM8 = 2'd1,
    SRC1_NPC  = 2'd2,
    SRC1_ZERO = 2'd3
  } src1sel_t;

  typedef struct packed {
    logic [SLOT_AW-1:0] dst;
    logic               we;
    logic               ld;
    logic               re0;
    logic               re1;
    logic [SLOT_AW-1:0] addr0;
    logic [SLOT_AW-1:0] addr1;
  } id_ex_slot_t;

  // Bubble: nothing written, nothing loaded, nothing read.
  localparam id_ex_slot_t ID_EX_BUBBLE = '0;

  // Map a 0-based tracking slot index to its bypass source id.
  function automatic fwd_sel_t fwd_stage(input int k);
    logic [1:0] v;
    v = 2'(k + 1);
    return fwd_sel_t'(v);
  endfunction

endpackage

// File: rtl/operand_fwd_unit_fwd_port_mux.sv
// Per-read-port bypass: compare the port address against every tracking
// slot and pick the youngest matching producer's result bus.
module fwd_port_mux
  import operand_fwd_unit_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NBYP = 2
) (
  input  logic                      re,
  input  logic [AW-1:0]             addr,
  input  logic [NBYP-1:0][AW-1:0]   slot_dst,
  input  logic [NBYP-1:0]           slot_we,
  input  logic [DW-1:0]             rf_data,
  input  logic [NBYP-1:0][DW-1:0]   res_byp,
  output logic [DW-1:0]             data,
  output fwd_sel_t                  fwd
);

  // Scan oldest to youngest so the youngest match overrides; r0 never bypasses.
  always_comb begin
    data = rf_data;
    fwd  = FWD_NONE;
    for (int k = NBYP - 1; k >= 0; k--) begin
      if (re && slot_we[k] && (slot_dst[k] == addr) && (addr != '0)) begin
        data = res_byp[k];
        fwd  = fwd_stage(k);
      end
    end
  end

endmodule

// File: rtl/operand_fwd_unit.sv
// ID/EX operand delivery: flops RF data and addresses, tracks in-flight
// destinations, self-generates bypass selects, detects load-use hazards
// and drives the src0/src1 busses plus the pipelined store data.
module operand_fwd_unit
  import operand_fwd_unit_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NBYP = 2,
  parameter int IMMW = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_ID_EX,
  input  logic                    stall_EX_DM,
  input  logic                    flush_ID_EX,
  input  logic [DW-1:0]           rf_p0,
  input  logic [DW-1:0]           rf_p1,
  input  logic [AW-1:0]           rf_addr0,
  input  logic [AW-1:0]           rf_addr1,
  input  logic                    rf_re0,
  input  logic                    rf_re1,
  input  logic [AW-1:0]           dst_addr_ID,
  input  logic                    we_ID,
  input  logic                    ld_ID,
  input  logic [NBYP-1:0][DW-1:0] res_byp,
  input  src0sel_t                src0sel_ID_EX,
  input  src1sel_t                src1sel_ID_EX,
  input  logic [IMMW-1:0]         imm_ID_EX,
  input  logic [DW-1:0]           pc_ID_EX,
  input  logic [DW-1:0]           SP,
  input  logic [DW-1:0]           MULH_EX_DM,
  output logic [DW-1:0]           src0,
  output logic [DW-1:0]           src1,
  output logic [DW-1:0]           p0_EX_DM,
  output logic                    load_use_stall,
  output fwd_sel_t                fwd0,
  output fwd_sel_t                fwd1
);

  // Immediate widened so every sign-extension slice exists for any IMMW.
  localparam int IW = (IMMW > 15) ? IMMW : 15;

  id_ex_slot_t                    id_ex;
  logic [1:0][DW-1:0]             p_q;
  logic [NBYP-1:0][SLOT_AW-1:0]   trk_dst;
  logic [NBYP-1:0]                trk_we;
  logic                           trk_ld1;   // load flag of the slot-1 occupant

  logic [SLOT_AW-1:0]             rd0_x, rd1_x, dst_x;
  logic [1:0]                     port_re;
  logic [1:0][SLOT_AW-1:0]        port_addr;
  logic [1:0][DW-1:0]             port_data;
  fwd_sel_t                       port_fwd [2];
  logic                           hit_id_ex, hit_s1;
  logic [IW-1:0]                  imm_x;

  assign rd0_x = SLOT_AW'(rf_addr0);
  assign rd1_x = SLOT_AW'(rf_addr1);
  assign dst_x = SLOT_AW'(dst_addr_ID);
  assign imm_x = IW'(imm_ID_EX);

  // Load-use: a load in ID_EX whose target the ID instruction reads. With a
  // single bypass stage the load is still unforwardable one slot later.
  always_comb begin
    hit_id_ex = id_ex.ld && id_ex.we && (id_ex.dst != '0) &&
                ((rf_re0 && (rd0_x == id_ex.dst)) || (rf_re1 && (rd1_x == id_ex.dst)));
    hit_s1    = (NBYP == 1) && trk_ld1 && trk_we[0] && (trk_dst[0] != '0) &&
                ((rf_re0 && (rd0_x == trk_dst[0])) || (rf_re1 && (rd1_x == trk_dst[0])));
    load_use_stall = !flush_ID_EX && (hit_id_ex || hit_s1);
  end

  // ID_EX control slot: flush beats stall; a load-use hazard inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex <= ID_EX_BUBBLE;
    end else if (flush_ID_EX) begin
      id_ex <= ID_EX_BUBBLE;
    end else if (!stall_ID_EX) begin
      if (load_use_stall) id_ex <= ID_EX_BUBBLE;
      else id_ex <= '{dst: dst_x, we: we_ID, ld: ld_ID, re0: rf_re0, re1: rf_re1,
                      addr0: rd0_x, addr1: rd1_x};
    end
  end

  // ID_EX register-file data, held with the slot on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (!stall_ID_EX) begin
      p_q[0] <= rf_p0;
      p_q[1] <= rf_p1;
    end
  end

  // Destination tracking shift register; slot 1 is fed straight from ID_EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_dst <= '0;
      trk_we  <= '0;
      trk_ld1 <= 1'b0;
    end else if (!stall_EX_DM) begin
      trk_dst[0] <= id_ex.dst;
      trk_we[0]  <= id_ex.we;
      trk_ld1    <= id_ex.ld;
      for (int k = 1; k < NBYP; k++) begin
        trk_dst[k] <= trk_dst[k-1];
        trk_we[k]  <= trk_we[k-1];
      end
    end
  end

  assign port_re   = {id_ex.re1, id_ex.re0};
  assign port_addr = {id_ex.addr1, id_ex.addr0};

  for (genvar p = 0; p < 2; p++) begin : g_port
    fwd_port_mux #(.DW(DW), .AW(SLOT_AW), .NBYP(NBYP)) u_mux (
      .re       (port_re[p]),
      .addr     (port_addr[p]),
      .slot_dst (trk_dst),
      .slot_we  (trk_we),
      .rf_data  (p_q[p]),
      .res_byp  (res_byp),
      .data     (port_data[p]),
      .fwd      (port_fwd[p])
    );
  end

  assign fwd0 = port_fwd[0];
  assign fwd1 = port_fwd[1];

  // Store data follows the bypassed port-0 operand into EX_DM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            p0_EX_DM <= '0;
    else if (!stall_EX_DM) p0_EX_DM <= port_data[0];
  end

  // src0 source mux; immediates are sign-extended to DW.
  always_comb begin
    src0 = '0;
    case (src0sel_ID_EX)
      SRC0_RF:    src0 = port_data[0];
      SRC0_IMM7:  src0 = DW'($signed(imm_x[6:0]));
      SRC0_IMM12: src0 = DW'($signed(imm_x[11:0]));
      SRC0_IMM15: src0 = DW'($signed(imm_x[14:0]));
      SRC0_SP:    src0 = SP;
      SRC0_MULH:  src0 = MULH_EX_DM;
      default:    src0 = '0;
    endcase
  end

  // src1 source mux.
  always_comb begin
    src1 = '0;
    case (src1sel_ID_EX)
      SRC1_RF:   src1 = port_data[1];
      SRC1_IMM8: src1 = DW'($signed(imm_x[7:0]));
      SRC1_NPC:  src1 = pc_ID_EX;
      default:   src1 = '0;
    endcase
  end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// checked against an instruction-level reference model.
module tb_operand_fwd_unit;
  import operand_fwd_unit_pkg::*;

  localparam int DW = 16, AW = 4, NBYP = 2, IMMW = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stall_ID_EX, stall_EX_DM, flush_ID_EX;
  logic [DW-1:0] rf_p0, rf_p1, pc_ID_EX, SP, MULH_EX_DM;
  logic [AW-1:0] rf_addr0, rf_addr1, dst_addr_ID;
  logic rf_re0, rf_re1, we_ID, ld_ID;
  logic [NBYP-1:0][DW-1:0] res_byp;
  src0sel_t src0sel_ID_EX;
  src1sel_t src1sel_ID_EX;
  logic [IMMW-1:0] imm_ID_EX;
  logic [DW-1:0] src0, src1, p0_EX_DM;
  logic load_use_stall;
  fwd_sel_t fwd0, fwd1;

  operand_fwd_unit #(.DW(DW), .AW(AW), .NBYP(NBYP), .IMMW(IMMW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
    .flush_ID_EX(flush_ID_EX), .rf_p0(rf_p0), .rf_p1(rf_p1), .rf_addr0(rf_addr0),
    .rf_addr1(rf_addr1), .rf_re0(rf_re0), .rf_re1(rf_re1), .dst_addr_ID(dst_addr_ID),
    .we_ID(we_ID), .ld_ID(ld_ID), .res_byp(res_byp), .src0sel_ID_EX(src0sel_ID_EX),
    .src1sel_ID_EX(src1sel_ID_EX), .imm_ID_EX(imm_ID_EX), .pc_ID_EX(pc_ID_EX), .SP(SP),
    .MULH_EX_DM(MULH_EX_DM), .src0(src0), .src1(src1), .p0_EX_DM(p0_EX_DM),
    .load_use_stall(load_use_stall), .fwd0(fwd0), .fwd1(fwd1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the instruction sitting in ID_EX and the producers
  // that have left it, youngest first.
  logic [DW-1:0] m_p0, m_p1, m_st;
  int  m_a0, m_a1, m_dst;
  bit  m_re0, m_re1, m_we, m_ld;
  int  s_dst [3];
  bit  s_we  [3];
  bit  s_ld1;
  // Values computed at the settle point, used again when the clock advances.
  logic [DW-1:0] x_b0;
  bit  x_lu;

  task automatic m_reset();
    m_p0 = '0; m_p1 = '0; m_st = '0;
    m_a0 = 0; m_a1 = 0; m_dst = 0;
    m_re0 = 0; m_re1 = 0; m_we = 0; m_ld = 0; s_ld1 = 0;
    for (int k = 0; k < 3; k++) begin s_dst[k] = 0; s_we[k] = 0; end
  endtask

  function automatic int youngest_writer(input bit re, input int a);
    if (!re || a == 0) return 0;
    for (int k = 0; k < NBYP; k++)
      if (s_we[k] && s_dst[k] == a) return k + 1;
    return 0;
  endfunction

  function automatic logic [DW-1:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = $signed(v << (32 - bits));
    t = t >>> (32 - bits);
    return t[DW-1:0];
  endfunction

  function automatic bit reads(input int a);
    return (rf_re0 && int'(rf_addr0) == a) || (rf_re1 && int'(rf_addr1) == a);
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic settle();
    int f0, f1;
    logic [DW-1:0] b1, e0, e1;
    #1;
    f0 = youngest_writer(m_re0, m_a0);
    f1 = youngest_writer(m_re1, m_a1);
    x_b0 = (f0 != 0) ? res_byp[f0-1] : m_p0;
    b1   = (f1 != 0) ? res_byp[f1-1] : m_p1;
    x_lu = m_ld && m_we && m_dst != 0 && reads(m_dst);
    if (NBYP == 1) x_lu = x_lu || (s_ld1 && s_we[0] && s_dst[0] != 0 && reads(s_dst[0]));
    if (flush_ID_EX) x_lu = 0;
    case (src0sel_ID_EX)
      SRC0_RF:    e0 = x_b0;
      SRC0_IMM7:  e0 = sext(32'(imm_ID_EX), 7);
      SRC0_IMM12: e0 = sext(32'(imm_ID_EX), 12);
      SRC0_IMM15: e0 = sext(32'(imm_ID_EX), 15);
      SRC0_SP:    e0 = SP;
      SRC0_MULH:  e0 = MULH_EX_DM;
      default:    e0 = '0;
    endcase
    case (src1sel_ID_EX)
      SRC1_RF:   e1 = b1;
      SRC1_IMM8: e1 = sext(32'(imm_ID_EX), 8);
      SRC1_NPC:  e1 = pc_ID_EX;
      default:   e1 = '0;
    endcase
    chk("src0", 32'(src0), 32'(e0));
    chk("src1", 32'(src1), 32'(e1));
    chk("fwd0", 32'(fwd0), 32'(f0));
    chk("fwd1", 32'(fwd1), 32'(f1));
    chk("load_use_stall", 32'(load_use_stall), 32'(x_lu));
    chk("p0_EX_DM", 32'(p0_EX_DM), 32'(m_st));
  endtask

  // Clock edge: retire the model state, then move to the next drive point.
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (!stall_EX_DM) begin
        for (int k = NBYP - 1; k >= 1; k--) begin s_dst[k] = s_dst[k-1]; s_we[k] = s_we[k-1]; end
        s_dst[0] = m_dst; s_we[0] = m_we; s_ld1 = m_ld; m_st = x_b0;
      end
      if (!stall_ID_EX) begin m_p0 = rf_p0; m_p1 = rf_p1; end
      if (flush_ID_EX || (!stall_ID_EX && x_lu)) begin
        m_we = 0; m_ld = 0; m_re0 = 0; m_re1 = 0;
      end else if (!stall_ID_EX) begin
        m_dst = int'(dst_addr_ID); m_we = we_ID; m_ld = ld_ID;
        m_a0 = int'(rf_addr0); m_a1 = int'(rf_addr1); m_re0 = rf_re0; m_re1 = rf_re1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    stall_ID_EX = 0; stall_EX_DM = 0; flush_ID_EX = 0;
    rf_p0 = '0; rf_p1 = '0; rf_addr0 = '0; rf_addr1 = '0; rf_re0 = 0; rf_re1 = 0;
    dst_addr_ID = '0; we_ID = 0; ld_ID = 0; res_byp = '0;
    src0sel_ID_EX = SRC0_RF; src1sel_ID_EX = SRC1_RF; imm_ID_EX = '0;
    pc_ID_EX = '0; SP = '0; MULH_EX_DM = '0;
  endtask

  task automatic writer(input int d, input bit ld);
    idle(); dst_addr_ID = AW'(d); we_ID = 1; ld_ID = ld;
  endtask

  task automatic reader(input int port, input int a, input logic [DW-1:0] v);
    idle();
    if (port == 0) begin rf_addr0 = AW'(a); rf_re0 = 1; rf_p0 = v; end
    else begin rf_addr1 = AW'(a); rf_re1 = 1; rf_p1 = v; end
  endtask

  task automatic randomize_inputs();
    stall_EX_DM = ($urandom_range(0, 7) == 0);
    stall_ID_EX = stall_EX_DM || ($urandom_range(0, 7) == 0);
    flush_ID_EX = ($urandom_range(0, 9) == 0);
    rf_p0 = DW'($urandom); rf_p1 = DW'($urandom);
    rf_addr0 = AW'($urandom_range(0, 3)); rf_addr1 = AW'($urandom_range(0, 3));
    rf_re0 = 1'($urandom); rf_re1 = 1'($urandom);
    dst_addr_ID = AW'($urandom_range(0, 3));
    we_ID = ($urandom_range(0, 3) != 0); ld_ID = ($urandom_range(0, 2) == 0);
    for (int k = 0; k < NBYP; k++) res_byp[k] = DW'($urandom);
    src0sel_ID_EX = src0sel_t'(3'($urandom_range(0, 7)));
    src1sel_ID_EX = src1sel_t'(2'($urandom_range(0, 3)));
    imm_ID_EX = IMMW'($urandom);
    pc_ID_EX = DW'($urandom); SP = DW'($urandom); MULH_EX_DM = DW'($urandom);
  endtask

  initial begin
    logic [DW-1:0] held_st;
    idle(); m_reset();
    repeat (2) @(negedge clk);
    settle();
    chk("reset_src0", 32'(src0), 0);
    chk("reset_p0_EX_DM", 32'(p0_EX_DM), 0);
    chk("reset_lus", 32'(load_use_stall), 0);
    advance();
    rst_n = 1;

    // Slot-1 bypass on port 0.
    writer(3, 0); settle(); advance();
    reader(0, 3, 16'h0BAD); settle(); advance();
    idle(); res_byp[0] = 16'h1234; settle();
    chk("t1_src0", 32'(src0), 32'h1234);
    chk("t1_fwd0", 32'(fwd0), 32'(FWD_S1));
    advance();

    // Two producers of r3: the younger one wins.
    writer(3, 0); settle(); advance();
    writer(3, 0); settle(); advance();
    reader(1, 3, 16'h0BAD); settle(); advance();
    idle(); res_byp[0] = 16'h1111; res_byp[1] = 16'h2222; settle();
    chk("t2_src1", 32'(src1), 32'h1111);
    chk("t2_fwd1", 32'(fwd1), 32'(FWD_S1));
    advance();

    // Load-use: one bubble, then bypass from slot 2.
    writer(5, 1); settle(); advance();
    reader(1, 5, 16'hDEAD); settle();
    chk("t3_lus_on", 32'(load_use_stall), 1);
    advance();
    settle();
    chk("t3_lus_off", 32'(load_use_stall), 0);
    advance();
    idle(); res_byp[1] = 16'h5A5A; settle();
    chk("t3_fwd1", 32'(fwd1), 32'(FWD_S2));
    chk("t3_src1", 32'(src1), 32'h5A5A);
    advance();

    // A write to r0 is never forwarded.
    writer(0, 0); settle(); advance();
    reader(0, 0, 16'h0000); settle(); advance();
    idle(); res_byp[0] = 16'hFFFF; settle();
    chk("t4_src0", 32'(src0), 0);
    chk("t4_fwd0", 32'(fwd0), 32'(FWD_NONE));
    advance();

    // Held pipeline keeps forwarding and holds store data.
    writer(7, 0); settle(); advance();
    reader(0, 7, 16'h0001); settle(); advance();
    idle(); stall_ID_EX = 1; stall_EX_DM = 1; res_byp[0] = 16'h7777;
    held_st = m_st;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t5_fwd0", 32'(fwd0), 32'(FWD_S1));
      chk("t5_src0", 32'(src0), 32'h7777);
      chk("t5_p0_EX_DM", 32'(p0_EX_DM), 32'(held_st));
      advance();
    end

    // Immediate sign extension.
    idle(); src0sel_ID_EX = SRC0_IMM12; imm_ID_EX = 15'h0800; settle();
    chk("t6_imm12", 32'(src0), 32'hF800);
    src0sel_ID_EX = SRC0_IMM15; imm_ID_EX = 15'h4000; settle();
    chk("t6_imm15", 32'(src0), 32'hC000);
    advance();

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if (i == 1500) begin
        src0sel_ID_EX = SRC0_RF; src1sel_ID_EX = SRC1_RF;
        rst_n = 0; m_reset();
        settle();
        chk("arst_src0", 32'(src0), 0);
        chk("arst_src1", 32'(src1), 0);
        chk("arst_p0_EX_DM", 32'(p0_EX_DM), 0);
        advance();
        rst_n = 1;
        settle();
        chk("arst_lus_after", 32'(load_use_stall), 0);
        advance();
      end else begin
        settle();
        advance();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fwd_unit.md
# operand_fwd_unit

Parametrised operand-delivery stage for the ID/EX boundary. It flops register-file read data and addresses and tracks the destination registers of in-flight instructions. It generates its own bypass selects over NBYP forwarding stages and detects load-use hazards. It drives the src0/src1 busses and the pipelined store data. It replaces the externally-selected bypass scheme: ID no longer computes bypass selects, it only presents register addresses and write/load flags.

## Interface
Parameters:
- DW, 16, datapath width
- AW, 4, register address width; register 0 is hard-wired zero
- NBYP, 2, forwarding stages (1..3); stage 1 = EX_DM, 2 = DM_WB, 3 = WB_RET
- IMMW, 15, immediate field width (≥ 12)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_ID_EX  in  1  hold ID_EX flops
- stall_EX_DM  in  1  hold EX_DM and later tracking slots; upstream guarantees stall_EX_DM implies stall_ID_EX
- flush_ID_EX  in  1  squash the instruction entering ID_EX
- rf_p0, rf_p1  in  DW  register-file read data (ID)
- rf_addr0, rf_addr1  in  AW  read addresses (ID)
- rf_re0, rf_re1  in  1  port actually read by the ID instruction
- dst_addr_ID  in  AW  destination of the ID instruction
- we_ID, ld_ID  in  1  ID instruction writes a register / is a load
- res_byp  in  NBYP×DW  result bus of stage k (index 0 = EX_DM)
- src0sel_ID_EX, src1sel_ID_EX  in  src0sel_t/src1sel_t  source selects
- imm_ID_EX  in  IMMW  immediate
- pc_ID_EX, SP, MULH_EX_DM  in  DW  next PC, stack pointer, XMULH high word
- src0, src1  out  DW  source busses (combinational)
- p0_EX_DM  out  DW  store data
- load_use_stall  out  1  ID must hold; a bubble is inserted into ID_EX
- fwd0, fwd1  out  fwd_sel_t  active bypass source per port (debug/coverage)

## Operation
- ID_EX slot, loaded when !stall_ID_EX:
  - p0/p1 data
  - addr0/1, re0/1
  - dst, we, ld
- Bubble: we = ld = re0 = re1 = 0. It is loaded on flush_ID_EX (wins over stall_ID_EX) or on load_use_stall (when not stalled).
- Tracking slots 1..NBYP hold {dst, we}:
  - slot 1 takes the ID_EX {dst, we} when !stall_EX_DM.
  - slot k takes slot k-1.
  - When stall_EX_DM=1, all slots hold and slot 1 is not re-bubbled.
  - When stall_ID_EX=1 and stall_EX_DM=0, slot 1 advances normally and the ID_EX slot holds.
- Per port p, bypass from the youngest slot k where: re_p, slot k we, slot k dst == addr_p, and addr_p != 0.
  - The bypassed value is res_byp[k-1].
  - With no such slot, the flopped RF data is used.
  - fwd_p reports NONE/S1/S2/S3.
- load_use_stall = ID_EX.ld & ID_EX.we & (ID_EX.dst != 0) & ((rf_re0 & rf_addr0 == ID_EX.dst) | (rf_re1 & rf_addr1 == ID_EX.dst)).
  - It is forced 0 while flush_ID_EX.
- src0 select:
  - RF: bypassed p0
  - IMM7: sext imm[6:0]
  - IMM12: sext imm[11:0]
  - IMM15: sext imm[14:0] (sext to DW in all cases)
  - SP
  - MULH
  - otherwise 0
- src1 select:
  - RF: bypassed p1
  - IMM8: sext imm[7:0]
  - NPC: pc_ID_EX
  - otherwise 0
- p0_EX_DM <= bypassed p0 when !stall_EX_DM.

## Timing
- Reset state: all data flops, tracking slots, p0_EX_DM and ID_EX fields are 0. We/ld/re bits are 0, so there is no bypass and no stall out of reset.
- src0, src1, fwd0/1 and load_use_stall are combinational, in the same cycle as their inputs.
- Latency: RF data to src busses 1 cycle; bypassed operand to p0_EX_DM 1 cycle.
- Load-use costs exactly one bubble. The next cycle the load is in slot 1, where its res_byp[0] is not yet valid data. The dependent instruction therefore reads from slot 2 one cycle later. For NBYP=1, ID must stall two cycles; for NBYP=1 load_use_stall extends to the slot-1 load as well.
- Multiple matching slots: the youngest wins. A write to r0 is never forwarded.
- Reset asserted mid-operation clears all slots immediately (async). Operations in flight are lost; no spurious forwarding follows deassertion.

## Structure
- Package common gains:
  - fwd_sel_t (NONE, S1, S2, S3)
  - a bubble constant for the ID_EX slot struct, id_ex_slot_t {dst, we, ld, re0, re1, addr0, addr1}
  - src0sel_t/src1sel_t are unchanged
- Sub-module fwd_port_mux (parametrised by DW, AW, NBYP): one instance per read port, doing the compare against the slots, the priority select and the fwd_sel_t output.
- The top level holds the flops, the tracking shift register, hazard detection and the source muxes.

## Test plan
- r3 written by ADD in slot 1 (res_byp[0]=16'h1234), ID_EX reads r3 on port0 → src0=16'h1234, fwd0=S1.
- r3 in slot 1 (16'h1111) and slot 2 (16'h2222), port1 reads r3 → src1=16'h1111, fwd1=S1.
- LW to r5 in ID_EX, ID reads r5 on port1 → load_use_stall=1 for one cycle, bubble in ID_EX. Next operand read bypasses from S2.
- Write to r0 in slot 1 with res_byp[0]=16'hFFFF, port0 reads r0 → src0=rf value 0, fwd0=NONE.
- stall_EX_DM=1 for 3 cycles with a r7 producer in slot 1 → forwarding to the held ID_EX consumer persists and p0_EX_DM holds.
- IMM12 select with imm=12'h800 → src0=16'hF800. Async reset mid-stream → all outputs 0 and no stall on the next cycle.
